// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: buffers one 16-word block, steps the external compressor
// through a load cycle and 64 rounds, then folds a..h into the chaining state H0..H7.
module sha256_round_ctrl (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         MSG_VALID,
  output logic         MSG_READY,
  input  logic [31:0]  MSG_WORD,
  input  logic         MSG_FIRST,
  input  logic         MSG_LAST,
  output logic         CMP_LOAD,
  output logic         CMP_EN,
  output logic [5:0]   CMP_I,
  output logic [31:0]  CMP_K,
  output logic [31:0]  CMP_W,
  input  logic [31:0]  CMP_A,
  input  logic [31:0]  CMP_B,
  input  logic [31:0]  CMP_C,
  input  logic [31:0]  CMP_D,
  input  logic [31:0]  CMP_E,
  input  logic [31:0]  CMP_F,
  input  logic [31:0]  CMP_G,
  input  logic [31:0]  CMP_H,
  output logic [31:0]  H0_OUT,
  output logic [31:0]  H1_OUT,
  output logic [31:0]  H2_OUT,
  output logic [31:0]  H3_OUT,
  output logic [31:0]  H4_OUT,
  output logic [31:0]  H5_OUT,
  output logic [31:0]  H6_OUT,
  output logic [31:0]  H7_OUT,
  output logic [255:0] DIGEST,
  output logic         DIGEST_VALID,
  input  logic         DIGEST_ACK,
  output logic         BUSY
);

  localparam int ROUNDS = 64;
  localparam int WORDS  = 16;

  localparam logic [5:0] LAST_RND  = 6'(ROUNDS - 1);
  localparam logic [3:0] LAST_WORD = 4'(WORDS - 1);
  localparam logic [5:0] MSG_RNDS  = 6'(WORDS);

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [2:0] {
    S_FILL,
    S_INIT,
    S_ROUND,
    S_UPDATE,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic [5:0]       rcnt_q, rcnt_d;
  logic             last_q, last_d;
  logic             accept, h_init, h_fold;
  logic             msg_ready_q, cmp_load_q, cmp_en_q, dvalid_q, busy_q;
  logic [31:0]      wbuf [WORDS];
  logic [0:7][31:0] h_q;
  logic [0:7][31:0] cmp_v;

  // Chaining-state fold wraps modulo 2^32; the carry out is dropped.
  function automatic logic [31:0] add_mod32(input logic [31:0] a, input logic [31:0] b);
    return a + b;
  endfunction

  assign cmp_v = {CMP_A, CMP_B, CMP_C, CMP_D, CMP_E, CMP_F, CMP_G, CMP_H};

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    last_d  = last_q;
    accept  = 1'b0;
    h_init  = 1'b0;
    h_fold  = 1'b0;
    case (state_q)
      S_FILL: begin
        if (MSG_VALID) begin
          accept = 1'b1;
          wcnt_d = wcnt_q + 4'd1;
          if ((wcnt_q == 4'd0) && MSG_FIRST) h_init = 1'b1;
          if (wcnt_q == LAST_WORD) begin
            last_d  = MSG_LAST;
            state_d = S_INIT;
          end
        end
      end
      S_INIT: begin
        rcnt_d  = 6'd0;
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (rcnt_q == LAST_RND) begin
          rcnt_d  = 6'd0;
          state_d = S_UPDATE;
        end else begin
          rcnt_d = rcnt_q + 6'd1;
        end
      end
      S_UPDATE: begin
        h_fold  = 1'b1;
        state_d = last_q ? S_DONE : S_FILL;
      end
      S_DONE: begin
        if (DIGEST_ACK) state_d = S_FILL;
      end
      default: state_d = S_FILL;
    endcase
  end

  // Control registers; strobes are decoded from the next state so every port is a flop.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_FILL;
      wcnt_q      <= 4'd0;
      rcnt_q      <= 6'd0;
      last_q      <= 1'b0;
      msg_ready_q <= 1'b1;
      cmp_load_q  <= 1'b0;
      cmp_en_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      last_q      <= last_d;
      msg_ready_q <= (state_d == S_FILL);
      cmp_load_q  <= (state_d == S_INIT);
      cmp_en_q    <= (state_d == S_ROUND);
      dvalid_q    <= (state_d == S_DONE);
      busy_q      <= !((state_d == S_FILL) && (wcnt_d == 4'd0));
    end
  end

  always_ff @(posedge CLK) begin
    if (accept) wbuf[wcnt_q] <= MSG_WORD;
  end

  always_ff @(posedge CLK) begin
    if (RESET || h_init) begin
      h_q <= IV;
    end else if (h_fold) begin
      for (int n = 0; n < 8; n++) h_q[n] <= add_mod32(h_q[n], cmp_v[n]);
    end
  end

  assign MSG_READY    = msg_ready_q;
  assign CMP_LOAD     = cmp_load_q;
  assign CMP_EN       = cmp_en_q;
  assign CMP_I        = rcnt_q;
  assign CMP_K        = K_ROM[rcnt_q];
  // Rounds 16..63 take their word from the compressor's own schedule expansion.
  assign CMP_W        = (cmp_en_q && (rcnt_q < MSG_RNDS)) ? wbuf[rcnt_q[3:0]] : 32'd0;
  assign DIGEST_VALID = dvalid_q;
  assign BUSY         = busy_q;
  assign DIGEST       = h_q;
  assign H0_OUT       = h_q[0];
  assign H1_OUT       = h_q[1];
  assign H2_OUT       = h_q[2];
  assign H3_OUT       = h_q[3];
  assign H4_OUT       = h_q[4];
  assign H5_OUT       = h_q[5];
  assign H6_OUT       = h_q[6];
  assign H7_OUT       = h_q[7];

endmodule
